// File: rtl/proc_pkg.sv
// Shared processor definitions: stack operation encoding and default datapath width.
package proc_pkg;

    localparam int PROC_DATA_W = 8;

    // Encoding of {StackWrite, StackRead}
    localparam logic [1:0] STK_NOP  = 2'b00;
    localparam logic [1:0] STK_POP  = 2'b01;
    localparam logic [1:0] STK_PUSH = 2'b10;
    localparam logic [1:0] STK_XCHG = 2'b11;

    typedef struct packed {
        logic overflowSet;
        logic underflowSet;
    } stackErr_t;

    function automatic logic [1:0] stackOp(input logic write, input logic read);
        return {write, read};
    endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// No reset on the array so it maps onto distributed RAM.
module stack_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              writeEn,
    input  logic [AW-1:0]     writeAddr,
    input  logic [DATA_W-1:0] writeData,
    input  logic [AW-1:0]     readAddr,
    output logic [DATA_W-1:0] readData
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (writeEn && (writeAddr < AW'(DEPTH))) begin
            mem[writeAddr] <= writeData;
        end
    end

    // Read index is Count-1, which wraps to all-ones when empty; return 0 there.
    always_comb begin
        readData = '0;
        if (readAddr < AW'(DEPTH)) begin
            readData = mem[readAddr];
        end
    end

endmodule

// File: rtl/param_stack_unit.sv
// Parametrised LIFO with occupancy, high-water mark, top peek, push+pop replace/bypass
// and sticky overflow/underflow flags. Count is the sole pointer.
module param_stack_unit
    import proc_pkg::*;
#(
    parameter  int DATA_W = PROC_DATA_W,
    parameter  int DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              StackWrite,
    input  logic              StackRead,
    input  logic [DATA_W-1:0] Datain,
    input  logic              ErrClear,
    output logic [DATA_W-1:0] Dataout,
    output logic [DATA_W-1:0] Top,
    output logic [CNT_W-1:0]  Count,
    output logic [CNT_W-1:0]  MaxCount,
    output logic              Empty,
    output logic              Full,
    output logic              Overflow,
    output logic              Underflow
);

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  nextCount;
    logic [CNT_W-1:0]  maxCount;
    logic [CNT_W-1:0]  readIdx;
    logic [CNT_W-1:0]  writeIdx;
    logic [DATA_W-1:0] readData;
    logic [DATA_W-1:0] dataOut;
    logic [DATA_W-1:0] nextDataOut;
    logic              writeEn;
    logic              overflow;
    logic              underflow;
    logic              isEmpty;
    logic              isFull;
    stackErr_t         errSet;

    assign isEmpty = (count == '0);
    assign isFull  = (count == CNT_W'(DEPTH));
    assign readIdx = count - CNT_W'(1);

    stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (CNT_W)
    ) u_stack_mem (
        .clk       (clk),
        .writeEn   (writeEn),
        .writeAddr (writeIdx),
        .writeData (Datain),
        .readAddr  (readIdx),
        .readData  (readData)
    );

    always_comb begin
        nextCount           = count;
        nextDataOut         = dataOut;
        writeEn             = 1'b0;
        writeIdx            = count;
        errSet.overflowSet  = 1'b0;
        errSet.underflowSet = 1'b0;
        case (stackOp(StackWrite, StackRead))
            STK_PUSH: begin
                if (isFull) begin
                    errSet.overflowSet = 1'b1;
                end else begin
                    writeEn   = 1'b1;
                    nextCount = count + CNT_W'(1);
                end
            end
            STK_POP: begin
                if (isEmpty) begin
                    errSet.underflowSet = 1'b1;
                end else begin
                    nextDataOut = readData;
                    nextCount   = count - CNT_W'(1);
                end
            end
            STK_XCHG: begin
                // Empty stack: the pushed word passes straight through to Dataout.
                if (isEmpty) begin
                    nextDataOut = Datain;
                end else begin
                    nextDataOut = readData;
                    writeEn     = 1'b1;
                    writeIdx    = readIdx;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            count     <= '0;
            maxCount  <= '0;
            dataOut   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count    <= nextCount;
            dataOut  <= nextDataOut;
            if (nextCount > maxCount) begin
                maxCount <= nextCount;
            end
            // A new error on the same edge as ErrClear wins.
            overflow  <= errSet.overflowSet  | (overflow  & ~ErrClear);
            underflow <= errSet.underflowSet | (underflow & ~ErrClear);
        end
    end

    assign Dataout   = dataOut;
    assign Top       = isEmpty ? '0 : readData;
    assign Count     = count;
    assign MaxCount  = maxCount;
    assign Empty     = isEmpty;
    assign Full      = isFull;
    assign Overflow  = overflow;
    assign Underflow = underflow;

endmodule

// File: tb/tb_param_stack_unit.sv
// Directed bench for param_stack_unit (DATA_W=8, DEPTH=4); Dataout checked by a scoreboard monitor.
module tb_param_stack_unit;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              Reset;
    logic              StackWrite;
    logic              StackRead;
    logic [DATA_W-1:0] Datain;
    logic              ErrClear;
    logic [DATA_W-1:0] Dataout;
    logic [DATA_W-1:0] Top;
    logic [CNT_W-1:0]  Count;
    logic [CNT_W-1:0]  MaxCount;
    logic              Empty;
    logic              Full;
    logic              Overflow;
    logic              Underflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        logic [7:0] value;
    } expItem_t;

    expItem_t sb[$];
    bit       stimDone = 0;

    param_stack_unit #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .StackWrite (StackWrite),
        .StackRead  (StackRead),
        .Datain     (Datain),
        .ErrClear   (ErrClear),
        .Dataout    (Dataout),
        .Top        (Top),
        .Count      (Count),
        .MaxCount   (MaxCount),
        .Empty      (Empty),
        .Full       (Full),
        .Overflow   (Overflow),
        .Underflow  (Underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Count > CNT_W'(DEPTH)) $error("Count exceeded DEPTH: %0d", Count);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every edge that samples a read presents a Dataout result on the next negedge.
    initial begin
        bit sampled;
        expItem_t e;
        forever begin
            @(posedge clk);
            sampled = StackRead && Reset;
            @(negedge clk);
            if (sampled) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dataout: got 0x%0h expected none", Dataout);
                end else begin
                    e = sb.pop_front();
                    chk(e.name, Dataout, e.value);
                end
            end
        end
    end

    // Drive one cycle from a negedge; expOut is queued when a read is issued.
    task automatic doOp(input logic w, input logic r, input logic [7:0] d,
                        input logic clr, input string name, input logic [7:0] expOut);
        expItem_t e;
        StackWrite = w;
        StackRead  = r;
        Datain     = d;
        ErrClear   = clr;
        if (r) begin
            e.name  = name;
            e.value = expOut;
            sb.push_back(e);
        end
        @(negedge clk);
        StackWrite = 1'b0;
        StackRead  = 1'b0;
        Datain     = '0;
        ErrClear   = 1'b0;
    endtask

    task automatic checkReset(input string tag);
        chk({tag, "_count"},     Count,     0);
        chk({tag, "_maxcount"},  MaxCount,  0);
        chk({tag, "_dataout"},   Dataout,   0);
        chk({tag, "_top"},       Top,       0);
        chk({tag, "_empty"},     Empty,     1);
        chk({tag, "_full"},      Full,      0);
        chk({tag, "_overflow"},  Overflow,  0);
        chk({tag, "_underflow"}, Underflow, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; StackWrite = 1'b0; StackRead = 1'b0; Datain = '0; ErrClear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkReset("rst");
        Reset = 1'b1;
        @(negedge clk);

        // 1: three pushes
        doOp(1, 0, 8'h11, 0, "", 8'h00);
        doOp(1, 0, 8'h22, 0, "", 8'h00);
        doOp(1, 0, 8'h33, 0, "", 8'h00);
        chk("t1_count", Count, 3);
        chk("t1_top", Top, 8'h33);
        chk("t1_empty", Empty, 0);
        chk("t1_full", Full, 0);
        chk("t1_maxcount", MaxCount, 3);

        // 2: fill, overflow, drain
        doOp(1, 0, 8'h44, 0, "", 8'h00);
        chk("t2_full", Full, 1);
        chk("t2_overflow_pre", Overflow, 0);
        doOp(1, 0, 8'h55, 0, "", 8'h00);
        chk("t2_count", Count, 4);
        chk("t2_overflow", Overflow, 1);
        chk("t2_top", Top, 8'h44);
        doOp(0, 1, 8'h00, 0, "t2_pop1", 8'h44);
        doOp(0, 1, 8'h00, 0, "t2_pop2", 8'h33);
        doOp(0, 1, 8'h00, 0, "t2_pop3", 8'h22);
        doOp(0, 1, 8'h00, 0, "t2_pop4", 8'h11);
        chk("t2_empty", Empty, 1);
        chk("t2_top_empty", Top, 0);
        chk("t2_maxcount", MaxCount, 4);

        // 3: underflow and clearing
        doOp(0, 1, 8'h00, 0, "t3_pop_empty", 8'h11);
        chk("t3_underflow", Underflow, 1);
        chk("t3_count", Count, 0);
        doOp(0, 0, 8'h00, 1, "", 8'h00);
        chk("t3_clr_overflow", Overflow, 0);
        chk("t3_clr_underflow", Underflow, 0);
        doOp(0, 1, 8'h00, 1, "t3_clr_pop", 8'h11);
        chk("t3_set_wins", Underflow, 1);
        doOp(0, 0, 8'h00, 1, "", 8'h00);
        chk("t3_clr2", Underflow, 0);

        // 4: replace and bypass
        doOp(1, 0, 8'hA0, 0, "", 8'h00);
        doOp(1, 0, 8'hB0, 0, "", 8'h00);
        doOp(1, 1, 8'hC0, 0, "t4_xchg", 8'hB0);
        chk("t4_count", Count, 2);
        chk("t4_top", Top, 8'hC0);
        doOp(0, 1, 8'h00, 0, "t4_pop1", 8'hC0);
        doOp(0, 1, 8'h00, 0, "t4_pop2", 8'hA0);
        doOp(1, 1, 8'h5A, 0, "t4_bypass", 8'h5A);
        chk("t4_bypass_count", Count, 0);
        chk("t4_bypass_ovf", Overflow, 0);
        chk("t4_bypass_udf", Underflow, 0);

        // 5: replace on a full stack
        doOp(1, 0, 8'h01, 0, "", 8'h00);
        doOp(1, 0, 8'h02, 0, "", 8'h00);
        doOp(1, 0, 8'h03, 0, "", 8'h00);
        doOp(1, 0, 8'h04, 0, "", 8'h00);
        doOp(1, 1, 8'h77, 0, "t5_xchg_full", 8'h04);
        chk("t5_count", Count, 4);
        chk("t5_overflow", Overflow, 0);
        chk("t5_top", Top, 8'h77);
        doOp(0, 1, 8'h00, 0, "t5_pop", 8'h77);
        chk("t5_count3", Count, 3);
        chk("t5_top3", Top, 8'h03);

        // 6: asynchronous reset between edges
        #2;
        Reset = 1'b0;
        #1;
        checkReset("t6_async");
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        chk("t6_maxcount", MaxCount, 0);
        doOp(1, 0, 8'h99, 0, "", 8'h00);
        chk("t6_count", Count, 1);
        chk("t6_top", Top, 8'h99);
        chk("t6_maxcount_after", MaxCount, 1);

        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        stimDone = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/param_stack_unit.md
Name: param_stack_unit

Overview:
Parametrised hardware LIFO. It replaces the fixed 8-bit processor stack used for CALL/RET and PUSH/POP.
- Generalised in data width and depth.
- Adds full/empty status, occupancy count, high-water mark, a combinational top-of-stack peek, defined simultaneous push+pop (replace/bypass), and sticky overflow/underflow error flags.
- Sits between the ALU result bus (push data) and the register-file/PC write-back muxes (pop data). Control logic drives it.

Parameters:
- DATA_W, 8, width of each stack entry.
- DEPTH, 16, number of entries; any value >= 2, need not be a power of two.
- CNT_W, $clog2(DEPTH+1), derived width of occupancy/pointer fields; not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- StackWrite  in  1  push request, sampled at rising clk.
- StackRead  in  1  pop request, sampled at rising clk.
- Datain  in  DATA_W  push data.
- ErrClear  in  1  synchronous clear of sticky error flags.
- Dataout  out  DATA_W  registered pop result.
- Top  out  DATA_W  combinational peek of current top entry; 0 when empty.
- Count  out  CNT_W  current occupancy, 0..DEPTH.
- MaxCount  out  CNT_W  high-water mark of Count since reset.
- Empty  out  1  Count == 0.
- Full  out  1  Count == DEPTH.
- Overflow  out  1  sticky; set by a rejected push.
- Underflow  out  1  sticky; set by a rejected pop.

Behaviour:
- Reset (Reset=0, async):
  - Count=0, MaxCount=0, Dataout=0, Overflow=0, Underflow=0.
  - Empty=1, Full=0.
  - Storage array is not cleared; Top=0 because the stack is empty.
- Operation is decoded each rising edge from {StackWrite, StackRead}:
  - 00: hold all state.
  - 10, not full: mem[Count] <= Datain; Count+1. Dataout unchanged.
  - 10, full: no write, Count unchanged, Overflow <= 1.
  - 01, not empty: Dataout <= mem[Count-1]; Count-1. Popped entry is not erased.
  - 01, empty: Dataout holds, Count stays 0, Underflow <= 1.
  - 11, not empty (including full): replace. Dataout <= mem[Count-1]; mem[Count-1] <= Datain; Count unchanged; no error flag.
  - 11, empty: bypass. Dataout <= Datain; Count stays 0; no write; no error flag.
- Latency:
  - Pop data is valid on Dataout the cycle after the pop edge.
  - Top reflects a push in the same cycle its Count update is visible, i.e. one cycle after the push edge.
- MaxCount <= max(MaxCount, next Count) every edge; it never decreases except on reset.
- ErrClear:
  - Clears Overflow and Underflow on the edge.
  - If an error condition occurs on the same edge, the set wins (flag = 1).
- Pointer arithmetic:
  - Count is the only pointer; the write index is Count, the read index is Count-1.
  - No wrap-around: an operation that would move Count outside 0..DEPTH is rejected as above.
- Reset asserted mid-operation: asynchronous; any in-flight push/pop on that edge is discarded.
- Release: Reset deassertion is synchronised externally; the block samples its first request on the first edge with Reset=1.
- Illegal states: none reachable. Count > DEPTH is impossible by construction and is covered by an assertion in the bench.

Decomposition:
- Shared package proc_pkg holds:
  - the stack-op encoding constants STK_NOP=2'b00, STK_POP=2'b01, STK_PUSH=2'b10, STK_XCHG=2'b11;
  - the default DATA_W=8 constant used by the processor.
- One sub-module, stack_mem: single write port, single asynchronous read port, parametrised by DATA_W and DEPTH.
  - It supplies both Top and the pop data.
  - Keeps the array inferrable as distributed RAM.
- The pointer/flag control stays in param_stack_unit.

Test Plan:
(All cases use DATA_W=8, DEPTH=4.)
1. Reset, then push 0x11, 0x22, 0x33 -> Count=3, Top=0x33, Empty=0, Full=0, MaxCount=3.
2. Push a 4th value 0x44, then push 0x55 -> Full=1, Count=4, Overflow=1, Top=0x44. Then pop x4 -> Dataout sequence 0x44, 0x33, 0x22, 0x11, Empty=1.
3. Pop while empty -> Underflow=1, Dataout stays 0x11. Then assert ErrClear for one cycle -> Overflow=0, Underflow=0. Assert ErrClear together with a pop while empty -> Underflow stays 1.
4. With stack holding 0xA0, 0xB0, assert push+pop with Datain=0xC0 -> Dataout=0xB0, Count=2, Top=0xC0. With stack empty, push+pop with Datain=0x5A -> Dataout=0x5A, Count=0, no flags set.
5. Full stack, push+pop with 0x77 -> Count=4, Overflow=0, Top=0x77, Dataout = previous top.
6. Drop Reset to 0 asynchronously between edges while Count=3 -> all outputs at reset values immediately. After release, MaxCount=0 and the first push gives Count=1.
